car_sprite_drawer: RTL and testbench

- Consumer side of the car-position interface. Takes the car's current track location (ox_loc/oy_loc) from the movement controller.
- Converts each location change into a pixel stream for the VGA adapter: a filled-box erase of the previously drawn car, then a filled-box draw at the new location.
- Tracks the last drawn position internally, so the erase location never depends on the controller's erase outputs.
- Sits between the car movement controller and the VGA adapter's x/y/colour/plot inputs.

---
 rtl/car_sprite_drawer.sv | 146 ++++++++++++++
 tb/tb_car_sprite_drawer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/car_sprite_drawer.sv
// car_sprite_drawer: turns car location changes into a VGA pixel stream.
// Each update erases the box at the last drawn position and then draws the
// box at the new target, one pixel per cycle in raster order. Pixels that
// land off-screen still take their cycle but are not plotted. All outputs
// are registered from state, counters and position registers, so the
// location inputs have no combinational path to any output.
module car_sprite_drawer #(
    parameter int unsigned CAR_W      = 20,
    parameter int unsigned CAR_H      = 20,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter logic [2:0]  BG_COLOUR  = 3'b000,
    parameter logic [2:0]  CAR_COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ox_loc,
    input  logic [6:0] oy_loc,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] LP_SCREEN_W = 9'(SCREEN_W);
    localparam logic [7:0] LP_SCREEN_H = 8'(SCREEN_H);
    localparam logic [4:0] LP_LAST_X   = 5'(CAR_W - 1);
    localparam logic [4:0] LP_LAST_Y   = 5'(CAR_H - 1);

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        ERASE,
        DRAW,
        DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_drawn_x;
    logic [6:0] r_drawn_y;
    logic [7:0] r_target_x;
    logic [6:0] r_target_y;
    logic [4:0] r_cx;
    logic [4:0] r_cy;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_on_screen;
    logic       w_last_col;
    logic       w_last_px;

    // Pixel address for the current counter position; erase uses the last
    // drawn origin, draw uses the latched target.
    always_comb begin
        w_base_x    = (r_state == ERASE) ? r_drawn_x : r_target_x;
        w_base_y    = (r_state == ERASE) ? r_drawn_y : r_target_y;
        w_sum_x     = {1'b0, w_base_x} + {4'b0000, r_cx};
        w_sum_y     = {1'b0, w_base_y} + {3'b000, r_cy};
        w_on_screen = (w_sum_x < LP_SCREEN_W) && (w_sum_y < LP_SCREEN_H);
        w_last_col  = (r_cx == LP_LAST_X);
        w_last_px   = w_last_col && (r_cy == LP_LAST_Y);
    end

    // Sequencer plus registered outputs decoded from the pre-edge state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= LOAD;
            r_drawn_x    <= '0;
            r_drawn_y    <= '0;
            r_target_x   <= '0;
            r_target_y   <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b1;
            case (r_state)
                LOAD: begin
                    r_target_x <= ox_loc;
                    r_target_y <= oy_loc;
                    r_cx       <= '0;
                    r_cy       <= '0;
                    r_state    <= DRAW;
                end
                IDLE: begin
                    r_busy <= 1'b0;
                    if ({ox_loc, oy_loc} != {r_drawn_x, r_drawn_y}) begin
                        r_target_x <= ox_loc;
                        r_target_y <= oy_loc;
                        r_cx       <= '0;
                        r_cy       <= '0;
                        r_state    <= ERASE;
                    end
                end
                ERASE, DRAW: begin
                    r_vga_x      <= w_sum_x[7:0];
                    r_vga_y      <= w_sum_y[6:0];
                    r_vga_colour <= (r_state == ERASE) ? BG_COLOUR : CAR_COLOUR;
                    r_plot       <= w_on_screen;
                    if (w_last_px) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= (r_state == ERASE) ? DRAW : DONE;
                    end else if (w_last_col) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 5'd1;
                    end else begin
                        r_cx <= r_cx + 5'd1;
                    end
                end
                DONE: begin
                    r_drawn_x <= r_target_x;
                    r_drawn_y <= r_target_y;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign plot       = r_plot;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_car_sprite_drawer.sv
// Bench for car_sprite_drawer: a queue-based model expands each update into
// its expected per-cycle output stream and is checked every cycle; a few
// literal pixel and cycle counts pin the model.
module tb_car_sprite_drawer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    car_sprite_drawer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ox_loc     (ox),
        .oy_loc     (oy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t        q[$];
    logic        m_load = 1'b1;
    logic [14:0] m_drawn = '0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          tot_plot = 0;
    int          tot_busy = 0;
    int          last_x = 0;
    int          last_y = 0;
    logic        got_done = 1'b0;
    logic        got_busy = 1'b0;
    logic        got_plot = 1'b0;
    int          snap_p;
    int          snap_b;

    task automatic push_box(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
        exp_t e;
        for (int yy = 0; yy < 20; yy++) begin
            for (int xx = 0; xx < 20; xx++) begin
                int sx;
                int sy;
                sx     = int'(bx) + xx;
                sy     = int'(by) + yy;
                e.plot = (sx < 160) && (sy < 120);
                e.x    = sx[7:0];
                e.y    = sy[6:0];
                e.c    = col;
                e.busy = 1'b1;
                e.done = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic push_done();
        exp_t e;
        e = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b1, done: 1'b1};
        q.push_back(e);
    endtask

    // One clock: sample inputs at the edge, advance the model, compare #1 later.
    task automatic cycle();
        exp_t        e;
        logic        s_rst;
        logic [14:0] s_loc;
        @(posedge clk);
        s_rst = reset_n;
        s_loc = {ox, oy};
        #1;
        e = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b0, done: 1'b0};
        if (!s_rst) begin
            q.delete();
            m_load  = 1'b1;
            m_drawn = '0;
        end else if (m_load) begin
            e.busy = 1'b1;
            push_box(s_loc[14:7], s_loc[6:0], 3'b100);
            push_done();
            m_drawn = s_loc;
            m_load  = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
        end else if (s_loc != m_drawn) begin
            push_box(m_drawn[14:7], m_drawn[6:0], 3'b000);
            push_box(s_loc[14:7], s_loc[6:0], 3'b100);
            push_done();
            m_drawn = s_loc;
        end
        n_checks++;
        if ({plot, busy, done} !== {e.plot, e.busy, e.done}) begin
            n_errors++;
            $display("FAIL ctl t=%0t plot/busy/done got %b%b%b want %b%b%b",
                     $time, plot, busy, done, e.plot, e.busy, e.done);
        end
        if (e.plot || !s_rst) begin
            n_checks++;
            if ({vga_x, vga_y, vga_colour} !== {e.x, e.y, e.c}) begin
                n_errors++;
                $display("FAIL pix t=%0t x/y/c got %0d/%0d/%0d want %0d/%0d/%0d",
                         $time, vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
        end
        tot_plot += int'(plot);
        tot_busy += int'(busy);
        if (plot === 1'b1) begin
            last_x = int'(vga_x);
            last_y = int'(vga_y);
        end
        got_done = done;
        got_busy = busy;
        got_plot = plot;
    endtask

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (got_done !== 1'b1 && n < 2000);
        if (got_done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s timeout waiting for done got 0 want 1", name);
        end
    endtask

    task automatic snap();
        snap_p = tot_plot;
        snap_b = tot_busy;
    endtask

    initial begin
        reset_n = 1'b0;
        ox      = 8'd70;
        oy      = 7'd85;
        repeat (3) cycle();
        reset_n = 1'b1;

        // Initial draw at (70,85), no erase.
        snap();
        wait_done("init");
        chk("init_plots", tot_plot - snap_p, 400);
        chk("init_busy", tot_busy - snap_b, 402);
        chk("init_last_x", last_x, 89);
        chk("init_last_y", last_y, 104);
        cycle();
        chk("init_busy_fall", int'(got_busy), 0);

        // Move 70 -> 30.
        ox = 8'd30;
        snap();
        wait_done("move30");
        chk("move30_plots", tot_plot - snap_p, 800);
        chk("move30_busy", tot_busy - snap_b, 801);
        chk("move30_last_x", last_x, 49);

        // Stable input: nothing happens.
        snap();
        repeat (1000) cycle();
        chk("stable_plots", tot_plot - snap_p, 0);
        chk("stable_busy", tot_busy - snap_b, 0);

        // Clipped draw at (150,110).
        ox = 8'd150;
        oy = 7'd110;
        snap();
        wait_done("clip");
        chk("clip_plots", tot_plot - snap_p, 500);
        chk("clip_last_x", last_x, 159);
        chk("clip_last_y", last_y, 119);

        // Back to (30,85): clipped erase then full draw.
        ox = 8'd30;
        oy = 7'd85;
        snap();
        wait_done("back");
        chk("back_plots", tot_plot - snap_p, 500);

        // 30 -> 70 with a toggle to 110 and back during ERASE.
        snap();
        ox = 8'd70;
        repeat (100) cycle();
        ox = 8'd110;
        repeat (50) cycle();
        ox = 8'd70;
        wait_done("toggle");
        repeat (20) cycle();
        chk("toggle_plots", tot_plot - snap_p, 800);
        chk("toggle_busy", tot_busy - snap_b, 801);
        chk("toggle_last_x", last_x, 89);

        // 70 -> 30, then 30 -> 70 with a change to 110 during DRAW.
        ox = 8'd30;
        wait_done("pre_draw_change");
        ox = 8'd70;
        snap();
        repeat (500) cycle();
        ox = 8'd110;
        wait_done("draw_change_first");
        chk("draw_change_first_x", last_x, 89);
        wait_done("draw_change_second");
        chk("draw_change_plots", tot_plot - snap_p, 1600);
        chk("draw_change_last_x", last_x, 129);
        chk("draw_change_last_y", last_y, 104);

        // Reset in mid-ERASE of a 110 -> 30 move.
        ox = 8'd30;
        repeat (100) cycle();
        reset_n = 1'b0;
        cycle();
        chk("rst_plot", int'(got_plot), 0);
        chk("rst_busy", int'(got_busy), 0);
        chk("rst_done", int'(got_done), 0);
        reset_n = 1'b1;
        snap();
        wait_done("post_rst");
        chk("post_rst_plots", tot_plot - snap_p, 400);
        chk("post_rst_busy", tot_busy - snap_b, 402);
        chk("post_rst_last_x", last_x, 49);
        chk("post_rst_last_y", last_y, 104);
        repeat (5) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
